// File: rtl/tlb_op_unit.sv
// Sequencer for TLB maintenance ops (SRCH/RD/WR/FILL/INV): accept, one EXEC cycle
// against the TLB ports, then a done pulse with registered search/read results.
module tlb_op_unit #(
  parameter int TLBNUM = 16,
  parameter int IDXW   = $clog2(TLBNUM)
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            op_valid,
  input  logic [2:0]      op_code,
  output logic            op_ready,
  input  logic [4:0]      inv_op,
  input  logic [9:0]      inv_asid,
  input  logic [18:0]     inv_vppn,
  input  logic [IDXW-1:0] csr_index,
  input  logic            csr_ne,
  input  logic [5:0]      csr_ecode,
  input  logic [88:0]     csr_entry,
  input  logic [18:0]     mem_s1_vppn,
  input  logic            mem_s1_va_bit12,
  input  logic [9:0]      mem_s1_asid,
  output logic [18:0]     tlb_s1_vppn,
  output logic            tlb_s1_va_bit12,
  output logic [9:0]      tlb_s1_asid,
  input  logic            tlb_s1_found,
  input  logic [IDXW-1:0] tlb_s1_index,
  output logic            tlb_we,
  output logic [IDXW-1:0] tlb_w_index,
  output logic [88:0]     tlb_w_entry,
  output logic [IDXW-1:0] tlb_r_index,
  input  logic [88:0]     tlb_r_entry,
  output logic            tlb_inv_valid,
  output logic [4:0]      tlb_inv_op,
  output logic            done,
  output logic            res_found,
  output logic [IDXW-1:0] res_index,
  output logic [88:0]     res_entry
);

  localparam logic [2:0] OP_SRCH = 3'd0;
  localparam logic [2:0] OP_RD   = 3'd1;
  localparam logic [2:0] OP_WR   = 3'd2;
  localparam logic [2:0] OP_FILL = 3'd3;
  localparam logic [2:0] OP_INV  = 3'd4;

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t          state;
  logic [IDXW-1:0] fill_cnt;

  logic [2:0]      op_q;
  logic [4:0]      inv_op_q;
  logic [9:0]      inv_asid_q;
  logic [18:0]     inv_vppn_q;
  logic [IDXW-1:0] index_q;
  logic            ne_q;
  logic [5:0]      ecode_q;
  logic [87:0]     entry_q;
  logic [IDXW-1:0] cnt_q;

  logic exec, is_srch, is_rd, is_wr, is_fill, is_inv, wr_e;
  logic unused;

  // The e bit of the incoming image is recomputed from ecode/ne on writes.
  assign unused = csr_entry[88];

  assign op_ready = (state == IDLE);
  assign exec     = (state == EXEC);
  assign is_srch  = (op_q == OP_SRCH);
  assign is_rd    = (op_q == OP_RD);
  assign is_wr    = (op_q == OP_WR);
  assign is_fill  = (op_q == OP_FILL);
  assign is_inv   = (op_q == OP_INV);
  assign wr_e     = (ecode_q == 6'h3F) | ~ne_q;

  // Control state, fill counter and result registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      fill_cnt  <= '0;
      done      <= 1'b0;
      res_found <= 1'b0;
      res_index <= '0;
      res_entry <= '0;
    end else begin
      fill_cnt <= (fill_cnt == IDXW'(TLBNUM - 1)) ? '0 : fill_cnt + 1'b1;
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (op_valid) state <= EXEC;
        end
        EXEC: begin
          state <= DONE;
          done  <= 1'b1;
          if (is_srch) begin
            res_found <= tlb_s1_found;
            res_index <= tlb_s1_index;
          end else if (is_rd) begin
            res_found <= tlb_r_entry[88];
            res_entry <= tlb_r_entry[88] ? tlb_r_entry : '0;
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          done  <= 1'b0;
        end
      endcase
    end
  end

  // Request capture on acceptance; data only, no reset needed
  always_ff @(posedge clk) begin
    if (op_ready && op_valid) begin
      op_q       <= op_code;
      inv_op_q   <= inv_op;
      inv_asid_q <= inv_asid;
      inv_vppn_q <= inv_vppn;
      index_q    <= csr_index;
      ne_q       <= csr_ne;
      ecode_q    <= csr_ecode;
      entry_q    <= csr_entry[87:0];
      cnt_q      <= fill_cnt;
    end
  end

  // Search port 1 is borrowed only during EXEC; otherwise the MEM stage owns it.
  always_comb begin
    tlb_s1_vppn     = mem_s1_vppn;
    tlb_s1_va_bit12 = mem_s1_va_bit12;
    tlb_s1_asid     = mem_s1_asid;
    if (exec) begin
      tlb_s1_va_bit12 = 1'b0;
      if (is_inv) begin
        tlb_s1_vppn = inv_vppn_q;
        tlb_s1_asid = inv_asid_q;
      end else begin
        tlb_s1_vppn = entry_q[87:69];
        tlb_s1_asid = entry_q[62:53];
      end
    end
  end

  assign tlb_we        = exec && (is_wr || is_fill);
  assign tlb_w_index   = is_fill ? cnt_q : index_q;
  assign tlb_w_entry   = {wr_e, entry_q};
  assign tlb_r_index   = index_q;
  assign tlb_inv_valid = exec && is_inv && (inv_op_q <= 5'd6);
  assign tlb_inv_op    = inv_op_q;

endmodule
